// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and M-extension decode helpers
// for the execute-stage ALU.
package alu_pkg;

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_SUB    = 5'b10000;
  localparam logic [4:0] OP_SLL    = 5'b00001;
  localparam logic [4:0] OP_SLT    = 5'b00010;
  localparam logic [4:0] OP_SLTU   = 5'b00011;
  localparam logic [4:0] OP_XOR    = 5'b00100;
  localparam logic [4:0] OP_SRL    = 5'b00101;
  localparam logic [4:0] OP_SRA    = 5'b10101;
  localparam logic [4:0] OP_OR     = 5'b00110;
  localparam logic [4:0] OP_AND    = 5'b00111;
  localparam logic [4:0] OP_MUL    = 5'b01000;
  localparam logic [4:0] OP_MULH   = 5'b01001;
  localparam logic [4:0] OP_MULHSU = 5'b01010;
  localparam logic [4:0] OP_MULHU  = 5'b01011;
  localparam logic [4:0] OP_DIV    = 5'b01100;
  localparam logic [4:0] OP_DIVU   = 5'b01101;
  localparam logic [4:0] OP_REM    = 5'b01110;
  localparam logic [4:0] OP_REMU   = 5'b01111;

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} alu_state_e;

  function automatic logic is_mdu(input logic [4:0] op);
    return op[3];
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response handshake bundle between the issue stage and the ALU.
interface alu_exec_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      aluopcode;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;

  modport master (
    output in_valid, aluopcode, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, aluopcode, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Radix-2 iterative engine: unsigned shift-add multiply and restoring divide
// on operand magnitudes; one step per iter_en cycle, XLEN steps per op.
module alu_muldiv_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              iter_en,
  input  logic              div_mode,
  input  logic [XLEN-1:0]   a_mag,
  input  logic [XLEN-1:0]   b_mag,
  output logic              last_c,
  output logic [2*XLEN-1:0] acc
);
  localparam int unsigned CW = $clog2(XLEN);

  logic [CW-1:0]     count_q;
  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] acc_d;
  logic [XLEN-1:0]   b_q;
  logic              div_q;
  logic [XLEN:0]     mul_hi_c;
  logic [XLEN:0]     div_rem_c;
  logic [XLEN-1:0]   div_sub_c;
  logic              div_ge_c;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_hi_c  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_rem_c = acc_q[2*XLEN-1:XLEN-1];
    div_ge_c  = div_rem_c >= {1'b0, b_q};
    div_sub_c = XLEN'(div_rem_c - {1'b0, b_q});
    if (div_q) begin
      acc_d = div_ge_c ? {div_sub_c, acc_q[XLEN-2:0], 1'b1}
                       : {acc_q[2*XLEN-2:0], 1'b0};
    end else begin
      acc_d = {mul_hi_c, acc_q[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      div_q   <= 1'b0;
    end else if (start) begin
      count_q <= CW'(XLEN - 1);
      acc_q   <= {XLEN'(0), a_mag};
      b_q     <= b_mag;
      div_q   <= div_mode;
    end else if (iter_en) begin
      count_q <= count_q - CW'(1);
      acc_q   <= acc_d;
    end
  end

  assign last_c = (count_q == '0);
  assign acc    = acc_q;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle RV32I ops plus iterative M-extension ops.
// Define ALU_FAST_MUL_EN to run multiplies on a combinational multiplier.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  alu_exec_unit_if.slave   bus
);
  localparam int unsigned SHW = $clog2(XLEN);

  alu_state_e        state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              zero_q;
  logic              in_ready_c, accept_c, start_c, last_c;
  logic              launch_iter_c;
  logic [XLEN-1:0]   base_res_c, launch_res_c, fix_res_c;
  logic              sa_c, sb_c;
  logic [XLEN-1:0]   a_mag_c, b_mag_c;
  logic [2*XLEN-1:0] acc_c, prod_c;
  logic [XLEN-1:0]   quot_c, rem_c;
  logic [2:0]        op_q;
  logic              sa_q, sb_q, bz_q;
  logic [XLEN-1:0]   a_q;

  assign in_ready_c = !flush && ((state_q == IDLE) || (state_q == DONE && bus.out_ready));
  assign accept_c   = bus.in_valid && in_ready_c;

  // Single-cycle RV32I datapath
  always_comb begin
    base_res_c = '0;
    case (bus.aluopcode)
      OP_ADD:  base_res_c = bus.op_a + bus.op_b;
      OP_SUB:  base_res_c = bus.op_a - bus.op_b;
      OP_SLL:  base_res_c = bus.op_a << bus.op_b[SHW-1:0];
      OP_SLT:  base_res_c = XLEN'($signed(bus.op_a) < $signed(bus.op_b));
      OP_SLTU: base_res_c = XLEN'(bus.op_a < bus.op_b);
      OP_XOR:  base_res_c = bus.op_a ^ bus.op_b;
      OP_SRL:  base_res_c = bus.op_a >> bus.op_b[SHW-1:0];
      OP_SRA:  base_res_c = XLEN'($signed(bus.op_a) >>> bus.op_b[SHW-1:0]);
      OP_OR:   base_res_c = bus.op_a | bus.op_b;
      OP_AND:  base_res_c = bus.op_a & bus.op_b;
      default: base_res_c = '0;
    endcase
  end

  // Signedness of each operand for MULH/MULHSU/DIV/REM; the rest are unsigned
  always_comb begin
    sa_c    = bus.op_a[XLEN-1] && (bus.aluopcode[2:0] inside {3'b001, 3'b010, 3'b100, 3'b110});
    sb_c    = bus.op_b[XLEN-1] && (bus.aluopcode[2:0] inside {3'b001, 3'b100, 3'b110});
    a_mag_c = sa_c ? XLEN'(0) - bus.op_a : bus.op_a;
    b_mag_c = sb_c ? XLEN'(0) - bus.op_b : bus.op_b;
  end

`ifdef ALU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod_c;

  always_comb begin
    fast_prod_c   = {{XLEN{sa_c}}, bus.op_a} * {{XLEN{sb_c}}, bus.op_b};
    launch_iter_c = is_mdu(bus.aluopcode) && is_div(bus.aluopcode);
    if (!is_mdu(bus.aluopcode)) begin
      launch_res_c = base_res_c;
    end else if (bus.aluopcode[1:0] == 2'b00) begin
      launch_res_c = fast_prod_c[XLEN-1:0];
    end else begin
      launch_res_c = fast_prod_c[2*XLEN-1:XLEN];
    end
  end
`else
  always_comb begin
    launch_iter_c = is_mdu(bus.aluopcode);
    launch_res_c  = base_res_c;
  end
`endif

  alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_c),
    .iter_en  (state_q == ITER),
    .div_mode (is_div(bus.aluopcode)),
    .a_mag    (a_mag_c),
    .b_mag    (b_mag_c),
    .last_c   (last_c),
    .acc      (acc_c)
  );

  // Sign fixup, half selection and divide-by-zero resolution
  always_comb begin
    prod_c    = (sa_q ^ sb_q) ? (2*XLEN)'(0) - acc_c : acc_c;
    quot_c    = acc_c[XLEN-1:0];
    rem_c     = acc_c[2*XLEN-1:XLEN];
    fix_res_c = '0;
    case ({2'b01, op_q})
      OP_MUL:                       fix_res_c = prod_c[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res_c = prod_c[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res_c = bz_q ? '1
                                              : ((sa_q ^ sb_q) ? XLEN'(0) - quot_c : quot_c);
      OP_REM, OP_REMU:              fix_res_c = bz_q ? a_q
                                              : (sa_q ? XLEN'(0) - rem_c : rem_c);
      default:                      fix_res_c = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    start_c     = 1'b0;
    case (state_q)
      IDLE: ;
      ITER: if (last_c) state_d = FIX;
      FIX: begin
        state_d     = DONE;
        out_valid_d = 1'b1;
        result_d    = fix_res_c;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // accept is only possible from IDLE or a consumed DONE
    if (accept_c) begin
      if (launch_iter_c) begin
        state_d     = ITER;
        out_valid_d = 1'b0;
        start_c     = 1'b1;
      end else begin
        state_d     = DONE;
        out_valid_d = 1'b1;
        result_d    = launch_res_c;
      end
    end
    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      start_c     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= (result_d == '0);
    end
  end

  // Operation context held for the fixup cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      bz_q <= 1'b0;
      a_q  <= '0;
    end else if (start_c) begin
      op_q <= bus.aluopcode[2:0];
      sa_q <= sa_c;
      sb_q <= sb_c;
      bz_q <= (bus.op_b == '0);
      a_q  <= bus.op_a;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized self-checking bench for alu_exec_unit against an arithmetic
// reference model; honours ALU_FAST_MUL_EN for multiply latency.
module tb_alu_exec_unit;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_exec_unit_if #(.XLEN(32)) bus ();

  alu_exec_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (!op[3]) begin
      case (op)
        5'b00000: return a + b;
        5'b10000: return a - b;
        5'b00001: return a << b[4:0];
        5'b00010: return (sa < sb) ? 32'd1 : 32'd0;
        5'b00011: return (a < b) ? 32'd1 : 32'd0;
        5'b00100: return a ^ b;
        5'b00101: return a >> b[4:0];
        5'b10101: begin p = 64'(sa >>> b[4:0]); return p[31:0]; end
        5'b00110: return a | b;
        5'b00111: return a & b;
        default:  return 32'd0;
      endcase
    end
    case (op[2:0])
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * longint'(ua)); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = 64'(sa / sb); return p[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = 64'(sa % sb); return p[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Edges after the accept edge until out_valid is visible
  function automatic int lat_of(input logic [4:0] op);
    if (!op[3]) return 0;
`ifdef ALU_FAST_MUL_EN
    if (!op[2]) return 0;
`endif
    return 33;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  // One op: accept, measure latency, check result/zero, stall `hold` cycles, consume
  task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int hold);
    logic [31:0] exp;
    int          lat;
    exp = ref_alu(op, a, b);
    bus.aluopcode = op;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    #1 check({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(lat_of(op)));
    check({tag, " result"}, 64'(bus.result), 64'(exp));
    check({tag, " zero"}, 64'(bus.zero), 64'(exp == 32'd0));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, " hold result"}, 64'(bus.result), 64'(exp));
      check({tag, " hold in_ready"}, 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    #1 check({tag, " ready on consume"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, " valid cleared"}, 64'(bus.out_valid), 64'd0);
  endtask

  logic [4:0]  optab[18];
  logic [4:0]  s_op[8];
  logic [31:0] s_a[8], s_b[8];

  initial begin
    logic [4:0] op;
    bit         seen;

    optab = '{5'b00000, 5'b10000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
              5'b00101, 5'b10101, 5'b00110, 5'b00111, 5'b01000, 5'b01001,
              5'b01010, 5'b01011, 5'b01100, 5'b01101, 5'b01110, 5'b01111};
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.aluopcode = '0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.out_ready = 1'b0;

    #12;
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset in_ready", 64'(bus.in_ready), 64'd1);
    check("reset result", 64'(bus.result), 64'd0);
    check("reset zero", 64'(bus.zero), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back base ops, one per cycle
    s_op[0] = 5'b10000; s_a[0] = 32'd5;          s_b[0] = 32'd5;
    s_op[1] = 5'b10101; s_a[1] = 32'h8000_0000; s_b[1] = 32'd4;
    for (int k = 2; k < 8; k++) begin
      s_op[k] = optab[$urandom_range(0, 9)];
      s_a[k]  = rnd_val();
      s_b[k]  = rnd_val();
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.aluopcode = s_op[k];
      bus.op_a      = s_a[k];
      bus.op_b      = s_b[k];
      bus.in_valid  = 1'b1;
      #1 check("stream in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk); #1;
      check("stream valid", 64'(bus.out_valid), 64'd1);
      check("stream result", 64'(bus.result), 64'(ref_alu(s_op[k], s_a[k], s_b[k])));
      check("stream zero", 64'(bus.zero), 64'(ref_alu(s_op[k], s_a[k], s_b[k]) == 32'd0));
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("stream drain", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b0;

    do_op("mulh", 5'b01001, 32'hFFFF_FFFF, 32'd2, 0);
    do_op("mulhu", 5'b01011, 32'hFFFF_FFFF, 32'd2, 0);
    do_op("div0", 5'b01100, 32'd7, 32'd0, 0);
    do_op("rem0", 5'b01110, 32'd7, 32'd0, 0);
    do_op("div_ovf", 5'b01100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op("rem_ovf", 5'b01110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op("divu_stall", 5'b01101, 32'd100, 32'd7, 5);
    do_op("rem_neg", 5'b11110, 32'hFFFF_FFF9, 32'd2, 0);

    // Flush mid-iteration
    bus.aluopcode = 5'b01100; bus.op_a = 32'd1000; bus.op_b = 32'd3; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    #1 check("flush in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    #1 check("flush idle in_ready", 64'(bus.in_ready), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("flush no output", 64'(seen), 64'd0);
    do_op("post_flush_add", 5'b00000, 32'd1, 32'd2, 0);

    // Flush while a result is waiting
    bus.aluopcode = 5'b00000; bus.op_a = 32'd9; bus.op_b = 32'd9; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("done valid", 64'(bus.out_valid), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush done", 64'(bus.out_valid), 64'd0);

    // Randomized ops, bit4 of M opcodes randomly toggled, occasional undefined opcodes
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) < 3) op = 5'($urandom_range(0, 31));
      else begin
        op = optab[$urandom_range(0, 17)];
        if (op[3] && $urandom_range(0, 1) == 1) op[4] = 1'b1;
      end
      do_op($sformatf("rand%0d op%0h", i, op), op, rnd_val(), rnd_val(), $urandom_range(0, 2));
    end

    // Reset mid-iteration
    bus.aluopcode = 5'b01100; bus.op_a = 32'd50; bus.op_b = 32'd5; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst mid out_valid", 64'(bus.out_valid), 64'd0);
    check("rst mid in_ready", 64'(bus.in_ready), 64'd1);
    check("rst mid result", 64'(bus.result), 64'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("mul_3x4", 5'b01000, 32'd3, 32'd4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
